// File: rtl/timer_int_pkg.sv
// timer_int_pkg: shared state encoding, hold length and clog2 helper for the timer interrupt controller
package timer_int_pkg;
  typedef enum logic [2:0] {IDLE, REQ, SERVICE, CLEAR, HOLD} state_t;
  localparam int HOLD_CYCLES = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/timer_int_ctrl_if.sv
// timer_int_ctrl_if: CPU-side interrupt request/acknowledge handshake
interface timer_int_ctrl_if #(parameter int ID_W = 2);
  logic irq_req;
  logic [ID_W-1:0] irq_id;
  logic irq_ack;
  logic irq_eoi;
  modport master(output irq_req, irq_id, input irq_ack, irq_eoi);
  modport slave(input irq_req, irq_id, output irq_ack, irq_eoi);
endinterface

// File: rtl/timer_int_prio_enc.sv
// timer_int_prio_enc: lowest-index-first priority encoder
module timer_int_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (vec[i]) idx = W'(i);
    valid = |vec;
  end
endmodule

// File: rtl/timer_int_ctrl.sv
// timer_int_ctrl: fixed-priority arbiter presenting timer interrupts to the CPU and clearing the serviced source
module timer_int_ctrl
  import timer_int_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_SRC-1:0]  tim_int,
  input  logic [NUM_SRC-1:0]  src_mask,
  timer_int_ctrl_if.master    cpu,
  output logic [NUM_SRC-1:0]  pending_clear,
  output logic                busy,
  output logic                timeout_evt
);
  localparam int CNT_W = clog2(ACK_TIMEOUT + 1);
  state_t state, nstate;
  logic [NUM_SRC-1:0] tim_int_q, cand, clr_d;
  logic [ID_W-1:0] id_q, id_d, win;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0] hold, hold_d;
  logic req_q, req_d, tevt_d, valid;
  assign cand = tim_int_q & ~src_mask;
  assign cpu.irq_req = req_q;
  assign cpu.irq_id = id_q;
  timer_int_prio_enc #(.N(NUM_SRC), .W(ID_W)) u_enc (
    .vec(cand),
    .valid(valid),
    .idx(win)
  );
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      tim_int_q <= '0;
      req_q <= 1'b0;
      id_q <= '0;
      pending_clear <= '0;
      busy <= 1'b0;
      timeout_evt <= 1'b0;
      cnt <= '0;
      hold <= '0;
    end else begin
      state <= nstate;
      tim_int_q <= tim_int;
      req_q <= req_d;
      id_q <= id_d;
      pending_clear <= clr_d;
      busy <= nstate != IDLE;
      timeout_evt <= tevt_d;
      cnt <= cnt_d;
      hold <= hold_d;
    end
  end
  // Priority inside REQ: ack, then source loss, then timeout expiry
  always_comb begin
    nstate = state;
    req_d = req_q;
    id_d = id_q;
    clr_d = '0;
    tevt_d = 1'b0;
    cnt_d = '0;
    hold_d = '0;
    case (state)
      IDLE: if (valid) begin
        nstate = REQ;
        req_d = 1'b1;
        id_d = win;
      end
      REQ: if (cpu.irq_ack) begin
        nstate = SERVICE;
        req_d = 1'b0;
      end else if (!cand[id_q]) begin
        nstate = IDLE;
        req_d = 1'b0;
      end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
        nstate = IDLE;
        req_d = 1'b0;
        tevt_d = 1'b1;
      end else cnt_d = (cnt == '1) ? cnt : cnt + 1'b1;
      SERVICE: if (cpu.irq_eoi) begin
        nstate = CLEAR;
        clr_d = NUM_SRC'(1) << id_q;
      end
      CLEAR: nstate = HOLD;
      HOLD: if (hold == 2'(HOLD_CYCLES - 1)) nstate = IDLE; else hold_d = hold + 1'b1;
      default: nstate = IDLE;
    endcase
  end
endmodule

// File: doc/timer_int_ctrl.md
Name: timer_int_ctrl

Overview:
- Consumer end of the timer interrupt lines. Collects up to NUM_SRC level `tim_int` outputs from the timer `interrupt` blocks and arbitrates them by fixed priority.
- Presents one request at a time to the CPU side with an ID and a req/ack handshake. After end-of-interrupt, drives a one-cycle `interrupt_pending_clear` pulse back to the serviced source.
- Sits between the timer channels and the core's interrupt input.

Parameters:
- NUM_SRC, 4, number of timer interrupt sources.
- ID_W, 2, width of irq_id; must equal clog2(NUM_SRC), minimum 1.
- ACK_TIMEOUT, 16, cycles irq_req may stay unacknowledged before withdrawal; minimum 2.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- tim_int  in  NUM_SRC  level interrupt lines from the timer interrupt blocks.
- src_mask  in  NUM_SRC  1 = source excluded from arbitration.
- irq_ack  in  1  CPU accepts the current request; sampled only in REQ.
- irq_eoi  in  1  CPU end-of-interrupt; sampled only in SERVICE.
- irq_req  out  1  request to CPU.
- irq_id  out  ID_W  index of requested/serviced source.
- pending_clear  out  NUM_SRC  one-hot, one-cycle clear pulse to the source's interrupt_pending_clear.
- busy  out  1  high in every state except IDLE.
- timeout_evt  out  1  one-cycle pulse when a request is withdrawn on timeout.

Behaviour:
- Reset: state=IDLE; irq_req=0, irq_id=0, pending_clear=0, busy=0, timeout_evt=0, tim_int_q=0, timeout counter=0. Reset mid-operation aborts silently; no pending_clear pulse is emitted.
- Input stage: tim_int is registered once into tim_int_q. All decisions use tim_int_q.
- Candidate vector is tim_int_q & ~src_mask. Fixed priority: the lowest set index wins.
- All outputs are registered.
- FSM states: IDLE, REQ, SERVICE, CLEAR, HOLD.
- IDLE: if the candidate vector is nonzero, latch winner into irq_id, set irq_req=1 and busy=1, load the timeout counter, and go to REQ. Otherwise stay in IDLE.
- IDLE latency: tim_int rising before edge N gives tim_int_q=1 after N, and irq_req=1 after N+1.
- REQ, checked in priority order:
  - (a) irq_ack=1: irq_req=0, go to SERVICE.
  - (b) otherwise, if candidate[irq_id]=0 (source dropped or masked): withdraw; irq_req=0, go to IDLE, no clear pulse.
  - (c) otherwise, if the counter has expired after ACK_TIMEOUT cycles of irq_req high: irq_req=0, pulse timeout_evt, go to IDLE and re-arbitrate.
  - irq_id holds stable for the whole time irq_req is high.
- SERVICE: wait for irq_eoi=1, then go to CLEAR.
  - Source drop, mask changes and irq_ack are ignored in this state.
  - irq_id stays stable.
- CLEAR: exactly one cycle with pending_clear[irq_id]=1; all other bits 0. Then go to HOLD.
- HOLD: exactly 2 cycles. This lets the source status fall and tim_int_q follow, so a stale level never re-triggers. Then go to IDLE with busy=0.
- Simultaneous events:
  - New higher-priority sources arriving during REQ/SERVICE do not preempt; they are arbitrated next in IDLE.
  - irq_ack and a source drop in the same cycle: ack wins.
  - irq_ack on the expiry cycle: ack wins.
- A source that re-asserts after HOLD is serviced again normally.
- Minimum request-to-request spacing: 1 REQ + 1 SERVICE + 1 CLEAR + 2 HOLD + 1 IDLE = 6 cycles.
- Timeout counter is clog2(ACK_TIMEOUT+1) bits wide, saturating, and only active in REQ.

Decomposition:
- Shared package timer_int_pkg holds:
  - the state encoding constants (IDLE, REQ, SERVICE, CLEAR, HOLD);
  - a HOLD_CYCLES=2 constant;
  - a clog2 function.
- One natural sub-module: timer_int_prio_enc, a combinational lowest-index-first encoder that outputs valid and index from the candidate vector.
- FSM, counters and output registers stay in timer_int_ctrl.

Test Plan:
- Single source: reset, mask=0; raise tim_int[2] → irq_req=1, irq_id=2 two edges later. Ack → irq_req=0. Eoi → pending_clear=4'b0100 for exactly one cycle. Drop tim_int[2] on that clear → busy=0 after 2 HOLD cycles; no second request.
- Priority: raise tim_int[3] and tim_int[1] in the same cycle → irq_id=1 first. After its clear, irq_id=3 is requested. Raising tim_int[0] during SERVICE of 1 does not preempt; it is served before 3.
- Masking: src_mask=4'b0010 and tim_int[1]=1 → irq_req stays 0 for 20 cycles. Then set mask=0 → request with irq_id=1. Set mask[1]=1 again while in REQ → withdrawn next cycle, no pending_clear.
- Timeout: ACK_TIMEOUT=16, tim_int[0] held high, no ack → irq_req high 16 cycles, then a timeout_evt pulse. irq_req re-asserts with irq_id=0 after re-arbitration.
- Reset mid-service: assert sys_rst in SERVICE → next edge: all outputs 0, state IDLE, pending_clear never pulses. Release with tim_int[2] still high → fresh request, irq_id=2.
- Handshake corners: irq_eoi in REQ is ignored; irq_ack in IDLE is ignored; irq_ack and a source drop in the same cycle → SERVICE entered.
